// File: rtl/frame_fade_scanner_if.sv
// Display-side bundle between the cell array / top level and frame_fade_scanner.
// The master drives enable, generation strobe and live cells; the slave returns scan row and PWM cells.
interface frame_fade_scanner_if #(
    parameter int N  = 8,
    parameter int XW = $clog2(N) + 1
);
    logic             ena;
    logic             step;
    logic [N*N-1:0]   cells_in;
    logic [XW-1:0]    x;
    logic [N*N-1:0]   cells_out;
    logic             frame_drop;

    modport master (
        output ena,
        output step,
        output cells_in,
        input  x,
        input  cells_out,
        input  frame_drop
    );

    modport slave (
        input  ena,
        input  step,
        input  cells_in,
        output x,
        output cells_out,
        output frame_drop
    );
endinterface

// File: rtl/frame_fade_scanner.sv
// Tear-free frame buffer, row scanner and per-cell fade PWM feeding led_array_driver.
// Generations are captured one cycle after step and only become visible at frame boundaries.
module frame_fade_scanner #(
    parameter int N          = 8,
    parameter int DWELL_BITS = 12,
    parameter int XW         = $clog2(N) + 1
) (
    input logic                  clk,
    input logic                  rst,
    frame_fade_scanner_if.slave  bus
);
    localparam int CELLS = N * N;

    logic [DWELL_BITS-1:0]    dc_q, dc_d;
    logic [XW-1:0]            x_q, x_d;
    logic                     step_dly_q, step_dly_d;
    logic [CELLS-1:0]         shadow_q, shadow_d;
    logic                     pending_q, pending_d;
    logic [CELLS-1:0][1:0]    ghost_q, ghost_d;
    logic [CELLS-1:0]         cells_out_q, cells_out_d;
    logic                     frame_drop_q, frame_drop_d;

    logic                     wrap;
    logic                     boundary;
    logic                     advance;
    logic [1:0]               phase;

    // Slots lit per row dwell for a given fade level: alive=4, then 2, 1, off.
    function automatic logic [2:0] duty(input logic [1:0] g);
        logic [2:0] d;
        case (g)
            2'd3:    d = 3'd4;
            2'd2:    d = 3'd2;
            2'd1:    d = 3'd1;
            default: d = 3'd0;
        endcase
        return d;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] g);
        return (g == 2'd0) ? 2'd0 : g - 2'd1;
    endfunction

    always_comb begin
        wrap         = (dc_q == '1);
        boundary     = wrap && (x_q == XW'(N - 1));
        advance      = boundary && pending_q;
        phase        = dc_q[DWELL_BITS-1 -: 2];

        dc_d         = dc_q + DWELL_BITS'(1);
        x_d          = x_q;
        if (wrap) begin
            x_d = (x_q == XW'(N - 1)) ? '0 : x_q + XW'(1);
        end

        step_dly_d   = bus.step;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        ghost_d      = ghost_q;

        if (advance) begin
            for (int unsigned k = 0; k < CELLS; k++) begin
                ghost_d[k] = shadow_q[k] ? 2'd3 : sat_dec(ghost_q[k]);
            end
            pending_d = 1'b0;
        end

        // A capture coinciding with the boundary re-arms pending after the old shadow is consumed.
        if (step_dly_q) begin
            shadow_d  = bus.cells_in;
            pending_d = 1'b1;
        end

        frame_drop_d = step_dly_q && pending_q && !advance;

        for (int unsigned k = 0; k < CELLS; k++) begin
            cells_out_d[k] = bus.ena && ({1'b0, phase} < duty(ghost_q[k]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dc_q         <= '0;
            x_q          <= '0;
            step_dly_q   <= 1'b0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            ghost_q      <= '0;
            cells_out_q  <= '0;
            frame_drop_q <= 1'b0;
        end else begin
            dc_q         <= dc_d;
            x_q          <= x_d;
            step_dly_q   <= step_dly_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            ghost_q      <= ghost_d;
            cells_out_q  <= cells_out_d;
            frame_drop_q <= frame_drop_d;
        end
    end

    assign bus.x          = x_q;
    assign bus.cells_out  = cells_out_q;
    assign bus.frame_drop = frame_drop_q;
endmodule
